// File: rtl/uart_line_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_line_fifo_if
// Description : Byte-stream handshake bundle between the UART receiver,
//               the line buffer and the UART transmitter.
// Revision    : 1.0
// ============================================================================
interface uart_line_fifo_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  // master: the surrounding UART logic; slave: the line buffer
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/uart_line_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_line_fifo
// Description : Holds received bytes until a CR/LF terminator, a full buffer
//               or an idle timeout commits them, then streams them out.
// Revision    : 1.0
// ============================================================================
module uart_line_fifo #(
  parameter int DEPTH    = 64,
  parameter int ADDR_W   = 6,
  parameter int CLK_FRE  = 27,
  parameter int FLUSH_MS = 100
) (
  input  wire logic        clk,
  input  wire logic        rst,
  uart_line_fifo_if.slave  bus_if,
  output logic [ADDR_W:0]  level_o,
  output logic             drop_pulse_o,
  output logic [15:0]      drop_cnt_o
);

  localparam logic [ADDR_W:0] DEPTH_W    = (ADDR_W+1)'(DEPTH);
  localparam logic [31:0]     IDLE_LIMIT = 32'(CLK_FRE * 1000 * FLUSH_MS - 1);
  localparam bit              FLUSH_EN   = (FLUSH_MS != 0);

  logic [7:0]      mem_q [DEPTH];
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] cm_ptr_q, cm_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            drop_pulse_q, drop_pulse_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic [31:0]     idle_cnt_q, idle_cnt_d;

  logic [ADDR_W:0] level;
  logic [ADDR_W:0] committed;
  logic            full;
  logic            accept;
  logic            drop;
  logic            is_term;
  logic            load;
  logic            idle_hit;

  assign level     = wr_ptr_q - rd_ptr_q;
  assign committed = cm_ptr_q - rd_ptr_q;
  assign full      = (level == DEPTH_W);
  assign accept    = bus_if.in_valid && !full;
  assign drop      = bus_if.in_valid && full;
  assign is_term   = (bus_if.in_data == 8'h0D) || (bus_if.in_data == 8'h0A);
  assign load      = (!out_valid_q || bus_if.out_ready) && (committed != '0);
  assign idle_hit  = FLUSH_EN && (wr_ptr_q != cm_ptr_q) && (idle_cnt_q == IDLE_LIMIT);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    cm_ptr_d     = cm_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    drop_pulse_d = drop;
    drop_cnt_d   = drop_cnt_q;
    idle_cnt_d   = idle_cnt_q;

    if (accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    // Terminator outranks the forced commits so the line keeps its CR/LF
    if (accept && is_term) begin
      cm_ptr_d = wr_ptr_q + 1'b1;
    end else if (full && (committed == '0)) begin
      cm_ptr_d = wr_ptr_q;
    end else if (idle_hit) begin
      cm_ptr_d = wr_ptr_q;
    end

    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end

    if (!FLUSH_EN || accept || idle_hit || (wr_ptr_q == cm_ptr_q)) begin
      idle_cnt_d = 32'd0;
    end else begin
      idle_cnt_d = idle_cnt_q + 32'd1;
    end

    if (load) begin
      out_data_d  = mem_q[rd_ptr_q[ADDR_W-1:0]];
      rd_ptr_d    = rd_ptr_q + 1'b1;
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus_if.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Storage is never reset; only the pointers define what is valid
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus_if.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      cm_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= 16'h0000;
      idle_cnt_q   <= 32'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      cm_ptr_q     <= cm_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      drop_pulse_q <= drop_pulse_d;
      drop_cnt_q   <= drop_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

  assign bus_if.in_ready  = !full;
  assign bus_if.out_data  = out_data_q;
  assign bus_if.out_valid = out_valid_q;
  assign level_o          = level;
  assign drop_pulse_o     = drop_pulse_q;
  assign drop_cnt_o       = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_line_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_line_fifo
// Description : Directed self-checking bench for uart_line_fifo.
// Revision    : 1.0
// ============================================================================
module tb_uart_line_fifo;

  logic        clk;
  logic        rst;
  logic [6:0]  level0;
  logic        drop_pulse0;
  logic [15:0] drop_cnt0;
  logic [3:0]  level1;
  logic        drop_pulse1;
  logic [15:0] drop_cnt1;

  int n_checks;
  int n_fail;

  uart_line_fifo_if bus0 ();
  uart_line_fifo_if bus1 ();

  uart_line_fifo #(.DEPTH(64), .ADDR_W(6), .CLK_FRE(27), .FLUSH_MS(0)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .bus_if       (bus0),
    .level_o      (level0),
    .drop_pulse_o (drop_pulse0),
    .drop_cnt_o   (drop_cnt0)
  );

  uart_line_fifo #(.DEPTH(8), .ADDR_W(3), .CLK_FRE(1), .FLUSH_MS(1)) u_dut_fl (
    .clk          (clk),
    .rst          (rst),
    .bus_if       (bus1),
    .level_o      (level1),
    .drop_pulse_o (drop_pulse1),
    .drop_cnt_o   (drop_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [7:0] b);
    bus0.in_valid = 1'b1;
    bus0.in_data  = b;
    tick();
    bus0.in_valid = 1'b0;
  endtask

  task automatic send1(input logic [7:0] b);
    bus1.in_valid = 1'b1;
    bus1.in_data  = b;
    tick();
    bus1.in_valid = 1'b0;
  endtask

  logic [7:0] src [$];
  int         si;
  int         ri;
  int         n;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus0.in_valid = 1'b0; bus0.in_data = 8'h00; bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_data = 8'h00; bus1.out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst_out_valid", bus0.out_valid, 0);
    check_eq("rst_level", level0, 0);
    check_eq("rst_in_ready", bus0.in_ready, 1);
    check_eq("rst_drop_cnt", drop_cnt0, 0);
    check_eq("rst_fl_out_valid", bus1.out_valid, 0);

    // "AB" held until CR
    send0(8'h41); send0(8'h42); tick();
    check_eq("ab_hold_valid", bus0.out_valid, 0);
    check_eq("ab_hold_level", level0, 2);
    send0(8'h0D);
    check_eq("cr_latency_valid", bus0.out_valid, 0);
    tick();
    check_eq("ab_v0", bus0.out_valid, 1);
    check_eq("ab_d0", bus0.out_data, 8'h41);
    tick();
    check_eq("ab_d1", bus0.out_data, 8'h42);
    tick();
    check_eq("ab_d2", bus0.out_data, 8'h0D);
    check_eq("ab_v2", bus0.out_valid, 1);
    tick();
    check_eq("ab_end_valid", bus0.out_valid, 0);
    check_eq("ab_end_level", level0, 0);

    // Backpressure on "HI\n"
    bus0.out_ready = 1'b0;
    send0(8'h48); send0(8'h49); send0(8'h0A);
    tick(); tick(); tick();
    check_eq("hi_stall_valid", bus0.out_valid, 1);
    check_eq("hi_stall_data", bus0.out_data, 8'h48);
    bus0.out_ready = 1'b1;
    check_eq("hi_d0", bus0.out_data, 8'h48);
    tick();
    check_eq("hi_d1", bus0.out_data, 8'h49);
    tick();
    check_eq("hi_d2", bus0.out_data, 8'h0A);
    tick();
    check_eq("hi_end_valid", bus0.out_valid, 0);

    // Fill without terminator, then overflow drops
    bus0.out_ready = 1'b0;
    for (int i = 0; i < 64; i++) send0(8'h40 + 8'(i));
    check_eq("full_level", level0, 64);
    check_eq("full_in_ready", bus0.in_ready, 0);
    check_eq("full_valid", bus0.out_valid, 0);
    send0(8'h50);
    check_eq("drop1_pulse", drop_pulse0, 1);
    check_eq("drop1_cnt", drop_cnt0, 1);
    send0(8'h51);
    check_eq("drop2_pulse", drop_pulse0, 1);
    check_eq("drop2_cnt", drop_cnt0, 2);
    check_eq("autocommit_valid", bus0.out_valid, 1);
    check_eq("autocommit_level", level0, 63);
    tick();
    check_eq("drop_pulse_clear", drop_pulse0, 0);
    check_eq("full_hold_data", bus0.out_data, 8'h40);
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      check_eq("full_drain", bus0.out_data, 32'h40 + 32'(i));
      tick();
    end
    check_eq("full_drain_valid", bus0.out_valid, 0);
    check_eq("full_drain_level", level0, 0);

    // Wrap test with random backpressure, after reset to clear drop_cnt
    rst = 1'b1; tick(); rst = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 39; k++) src.push_back(8'h30 + 8'(k) + 8'(p));
      src.push_back(8'h0A);
    end
    si = 0;
    ri = 0;
    for (int cyc = 0; cyc < 3000 && ri < 120; cyc++) begin
      bus0.out_ready = 1'($urandom_range(0, 1));
      if (bus0.out_valid && bus0.out_ready) begin
        check_eq("wrap_data", bus0.out_data, 32'(src[ri]));
        ri++;
      end
      if (si < 120 && bus0.in_ready) begin
        bus0.in_valid = 1'b1;
        bus0.in_data  = src[si];
        si++;
      end else begin
        bus0.in_valid = 1'b0;
      end
      tick();
    end
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    check_eq("wrap_count", ri, 120);
    check_eq("wrap_drop_cnt", drop_cnt0, 0);
    check_eq("wrap_level", level0, 0);

    // Idle flush timing on the timeout instance
    send1(8'h58);
    n = 0;
    while (!bus1.out_valid && n < 1200) begin tick(); n++; end
    check_eq("flush_latency", n, 1001);
    check_eq("flush_data", bus1.out_data, 8'h58);
    tick();
    check_eq("flush_end_valid", bus1.out_valid, 0);
    send1(8'h59);
    repeat (499) tick();
    check_eq("restart_quiet", bus1.out_valid, 0);
    send1(8'h5A);
    n = 0;
    while (!bus1.out_valid && n < 1200) begin tick(); n++; end
    check_eq("restart_latency", n, 1001);
    check_eq("restart_d0", bus1.out_data, 8'h59);
    tick();
    check_eq("restart_d1", bus1.out_data, 8'h5A);
    tick();
    check_eq("restart_end_valid", bus1.out_valid, 0);

    // Reset mid-line with committed and pending bytes
    bus0.out_ready = 1'b0;
    send0(8'h61); send0(8'h62); send0(8'h0A);
    send0(8'h63); send0(8'h64); send0(8'h65); send0(8'h66); send0(8'h67);
    check_eq("mid_level", level0, 7);
    check_eq("mid_valid", bus0.out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_valid", bus0.out_valid, 0);
    check_eq("mid_rst_level", level0, 0);
    check_eq("mid_rst_drop_cnt", drop_cnt0, 0);
    check_eq("mid_rst_in_ready", bus0.in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
